// File: rtl/case_5_mul_share_arb.sv
// One signed A_W x B_W multiplier shared by NUM_REQ requesters through a round-robin
// arbiter, followed by an operand stage (S0) and a response stage (S1).
module case_5_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 10,
  parameter int B_W     = 6,
  parameter int P_W     = 14
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_ovf
);

  localparam int F_W = A_W + B_W;

  logic [ID_W-1:0]       ptr_reg;
  logic                  op_v_reg;
  logic signed [A_W-1:0] op_a_reg;
  logic signed [B_W-1:0] op_b_reg;
  logic [ID_W-1:0]       op_id_reg;

  logic [A_W-1:0]  a_arr    [NUM_REQ];
  logic [B_W-1:0]  b_arr    [NUM_REQ];
  logic [ID_W-1:0] cand_idx [NUM_REQ];

  logic            s1_free;
  logic            s0_free;
  logic            advance;
  logic            hs;
  logic            grant_any;
  logic [ID_W-1:0] win;

  logic signed [F_W-1:0] full;
  logic                  full_ovf;

  assign s1_free = !rsp_valid || rsp_ready;
  assign s0_free = !op_v_reg || s1_free;
  assign advance = op_v_reg && s1_free;

  // Per-requester operand slices and the search order starting at ptr.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]    = req_a[gi*A_W +: A_W];
      assign b_arr[gi]    = req_b[gi*B_W +: B_W];
      assign cand_idx[gi] = ID_W'((int'(ptr_reg) + gi) % NUM_REQ);
      assign req_ready[gi] = grant_any && s0_free && !ap_rst && (win == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    grant_any = 1'b0;
    win       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[cand_idx[k]]) begin
        grant_any = 1'b1;
        win       = cand_idx[k];
      end
    end
  end

  assign hs = |(req_valid & req_ready);

  // Full-precision product; overflow when the bits above the kept sign bit disagree.
  assign full     = op_a_reg * op_b_reg;
  assign full_ovf = (|full[F_W-1:P_W-1]) && !(&full[F_W-1:P_W-1]);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_reg   <= '0;
      op_v_reg  <= 1'b0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      op_id_reg <= '0;
    end else begin
      if (hs) begin
        op_v_reg  <= 1'b1;
        op_a_reg  <= a_arr[win];
        op_b_reg  <= b_arr[win];
        op_id_reg <= win;
        ptr_reg   <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end else if (advance) begin
        op_v_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      if (advance) begin
        rsp_valid <= 1'b1;
        rsp_data  <= full[P_W-1:0];
        rsp_id    <= op_id_reg;
        rsp_ovf   <= full_ovf;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/case_5_mul_share_arb.md
Name: case_5_mul_share_arb

Overview:
- Shares one signed 10x6 multiplier datapath (14-bit result) between NUM_REQ independent requesters.
- Round-robin arbitration selects one request per cycle.
- Operands are registered, multiplied, and the result is returned on a single valid/ready response channel tagged with the requester id.
- Sits between the per-loop operand producers of case_5 and the shared multiplier, replacing per-requester multiplier copies.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester tag (clog2(NUM_REQ))
- A_W, 10, signed operand A width
- B_W, 6, signed operand B width
- P_W, 14, returned product width (truncated)

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_a  in  NUM_REQ*A_W  operand A, requester i at bits [i*A_W +: A_W], signed
- req_b  in  NUM_REQ*B_W  operand B, requester i at bits [i*B_W +: B_W], signed
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  P_W  signed product, low P_W bits of the full product
- rsp_id  out  ID_W  index of the requester that issued this result
- rsp_ovf  out  1  full product not representable in P_W signed bits

Behaviour:
- Reset (async, ap_rst=1):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0.
  - Operand stage empty; rr pointer=0.
  - req_ready all 0 while ap_rst=1.
- Pipeline stages:
  - S0 is the operand register (op_v, op_a, op_b, op_id).
  - S1 is the output register (rsp_*).
- Stall rule:
  - s1_free = !rsp_valid || rsp_ready.
  - s0_free = !op_v || s1_free.
- Advance rule: when op_v && s1_free:
  - S1 loads the product of op_a and op_b with op_id.
  - rsp_valid goes to 1.
- Drain rule: if rsp_valid && rsp_ready && !op_v, rsp_valid goes to 0.
- Arbitration:
  - Combinational round-robin over req_valid, starting at index ptr, wrapping NUM_REQ-1 -> 0.
  - req_ready[g]=1 only for the winner g, and only when s0_free.
  - Handshake: req_valid[g] && req_ready[g] loads S0 from requester g and sets ptr = (g+1) mod NUM_REQ.
  - With no handshake, ptr holds and S0 keeps op_v=0 if it advanced.
- Requester rule: operands stay stable while valid and not ready. The block samples operands only on handshake and never depends on stability before it.
- Latency: a handshake at edge N gives rsp_valid=1 after edge N+1 when rsp_ready is held high.
- Throughput: 1 result/cycle with rsp_ready held high.
- Arithmetic:
  - full = signed(A_W) * signed(B_W), A_W+B_W = 16 bits.
  - rsp_data = full[P_W-1:0].
  - rsp_ovf = 1 iff full[15:13] are not all equal (value outside -8192..8191).
- Backpressure:
  - rsp_valid && !rsp_ready holds every rsp_* output stable.
  - S0 may still fill once; req_ready stays 0 while S0 is full and S1 is stalled.
- No loss or duplication: each handshake produces exactly one response, in acceptance order.
- Simultaneous events:
  - S1 drain and S0 advance in the same cycle is the normal pipelined case.
  - A new S0 load in the same cycle S0 advances is allowed (S0 was full, s1_free=1).
- Reset mid-operation discards S0/S1 contents; no response is produced for discarded requests.

Test Plan:
- Single request: req 1 issues a=-3, b=5, rsp_ready=1 -> two cycles later rsp_valid=1, rsp_data=0x3FF1 (-15), rsp_id=1, rsp_ovf=0.
- Overflow: req 0 issues a=511, b=31 -> rsp_data=0x3DE1, rsp_ovf=1. Then a=-512, b=-32 -> rsp_data=0x0000, rsp_ovf=1.
- Fairness: all 4 req_valid held high for 8 cycles with rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; results back-to-back with matching ids.
- Backpressure: rsp_ready=0 for 5 cycles with req 2 streaming -> exactly 2 requests accepted, then req_ready=0; rsp_* stable. Release -> both results delivered in order, no loss.
- Pointer wrap/skip: only req 3 and req 0 valid, ptr=1 -> req 3 granted first, then req 0, then ptr=1.
- Async reset: assert ap_rst between clock edges with S0 and S1 full -> rsp_valid drops immediately. After release, first grant goes to req 0 and no stale response appears.
